// File: rtl/uart_bus_pkg.sv
// Shared opcode/response byte values and FSM encoding for the UART-driven bus master.
package uart_bus_pkg;

  localparam logic [7:0] OP_WRITE    = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ     = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR     = 8'h45;  // 'E'
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // 'T'

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    BUS_REQ,
    BUS_WAIT,
    RESP,
    ERR
  } state_t;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/axi_uart.sv
// 8N1 UART with AXI-stream byte ports; one bit lasts prescale*8 clock cycles.
module axi_uart (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] prescale,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        rxd,
  output logic        txd,
  output logic        rx_frame_error
);

  logic [18:0] bit_last;
  logic [18:0] half_last;
  assign bit_last  = {prescale, 3'b000} - 19'd1;
  assign half_last = {1'b0, prescale, 2'b00} - 19'd1;

  logic [9:0]  tx_shift_reg;
  logic [3:0]  tx_bits_reg;
  logic [18:0] tx_cnt_reg;

  assign s_axis_tready = (tx_bits_reg == 4'd0);
  assign txd           = tx_shift_reg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift_reg <= 10'h3FF;
      tx_bits_reg  <= 4'd0;
      tx_cnt_reg   <= 19'd0;
    end else if (tx_bits_reg == 4'd0) begin
      if (s_axis_tvalid) begin
        tx_shift_reg <= {1'b1, s_axis_tdata, 1'b0};
        tx_bits_reg  <= 4'd10;
        tx_cnt_reg   <= bit_last;
      end
    end else if (tx_cnt_reg == 19'd0) begin
      tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
      tx_bits_reg  <= tx_bits_reg - 4'd1;
      tx_cnt_reg   <= bit_last;
    end else begin
      tx_cnt_reg <= tx_cnt_reg - 19'd1;
    end
  end

  logic        rxd_meta_reg;
  logic        rxd_sync_reg;
  logic [3:0]  rx_bits_reg;
  logic [18:0] rx_cnt_reg;
  logic [7:0]  rx_shift_reg;
  logic        rx_wait_high_reg;
  logic [7:0]  m_tdata_reg;
  logic        m_tvalid_reg;
  logic        frame_err_reg;

  assign m_axis_tdata   = m_tdata_reg;
  assign m_axis_tvalid  = m_tvalid_reg;
  assign rx_frame_error = frame_err_reg;

  // No holding buffer: a byte the consumer is not ready for when it completes is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_reg     <= 1'b1;
      rxd_sync_reg     <= 1'b1;
      rx_bits_reg      <= 4'd0;
      rx_cnt_reg       <= 19'd0;
      rx_shift_reg     <= 8'd0;
      rx_wait_high_reg <= 1'b0;
      m_tdata_reg      <= 8'd0;
      m_tvalid_reg     <= 1'b0;
      frame_err_reg    <= 1'b0;
    end else begin
      rxd_meta_reg  <= rxd;
      rxd_sync_reg  <= rxd_meta_reg;
      m_tvalid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      if (rx_wait_high_reg) begin
        if (rxd_sync_reg) rx_wait_high_reg <= 1'b0;
      end else if (rx_bits_reg == 4'd0) begin
        if (!rxd_sync_reg) begin
          rx_bits_reg <= 4'd10;
          rx_cnt_reg  <= half_last;
        end
      end else if (rx_cnt_reg != 19'd0) begin
        rx_cnt_reg <= rx_cnt_reg - 19'd1;
      end else begin
        rx_cnt_reg  <= bit_last;
        rx_bits_reg <= rx_bits_reg - 4'd1;
        if (rx_bits_reg == 4'd10) begin
          if (rxd_sync_reg) rx_bits_reg <= 4'd0;
        end else if (rx_bits_reg == 4'd1) begin
          if (rxd_sync_reg) begin
            m_tdata_reg  <= rx_shift_reg;
            m_tvalid_reg <= m_axis_tready;
          end else begin
            // Bad stop bit: wait for the line to idle before hunting for a start bit.
            frame_err_reg    <= 1'b1;
            rx_wait_high_reg <= 1'b1;
          end
        end else begin
          rx_shift_reg <= {rxd_sync_reg, rx_shift_reg[7:1]};
        end
      end
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// Turns UART command frames ('W'/'R' + LSB-first address/data) into single
// req/gnt/rvalid bus transactions and returns the result over the UART.
module uart_bus_master #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 32,
  parameter logic [15:0] PRESCALE    = 16'd54,
  parameter int          BUS_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxd_uart,
  output logic                  txd_uart,
  output logic                  master_data_req_o,
  output logic [ADDR_WIDTH-1:0] master_data_addr_o,
  output logic                  master_data_we_o,
  output logic [3:0]            master_data_be_o,
  output logic [DATA_WIDTH-1:0] master_data_wdata_o,
  input  logic                  master_data_gnt_i,
  input  logic                  master_data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] master_data_rdata_i,
  output logic                  busy_o
);

  import uart_bus_pkg::*;

  localparam int              TO_W    = $clog2(BUS_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUS_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  state_t                state_reg;
  logic [1:0]            byte_cnt_reg;
  logic [TO_W-1:0]       timeout_cnt_reg;
  logic [31:0]           addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  we_reg;
  logic                  req_reg;
  logic [7:0]            tx_data_reg;
  logic                  tx_valid_reg;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_accept;
  logic       rx_frame_error;
  logic       tx_ready;
  logic [7:0] rdata_byte [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rbyte
      assign rdata_byte[gi] = rdata_reg[8*gi +: 8];
    end
  endgenerate

  // Bytes are only taken while assembling a frame; anything else is dropped in the UART.
  assign rx_ready  = (state_reg == IDLE) || (state_reg == ADDR) || (state_reg == WDATA);
  assign rx_accept = rx_valid && rx_ready;

  assign master_data_req_o   = req_reg;
  assign master_data_addr_o  = addr_reg[ADDR_WIDTH-1:0];
  assign master_data_we_o    = we_reg;
  assign master_data_be_o    = 4'hF;
  assign master_data_wdata_o = wdata_reg;
  assign busy_o              = (state_reg != IDLE);

  axi_uart u_uart (
    .clk            (clk),
    .rst            (~reset),
    .prescale       (PRESCALE),
    .s_axis_tdata   (tx_data_reg),
    .s_axis_tvalid  (tx_valid_reg),
    .s_axis_tready  (tx_ready),
    .m_axis_tdata   (rx_data),
    .m_axis_tvalid  (rx_valid),
    .m_axis_tready  (rx_ready),
    .rxd            (rxd_uart),
    .txd            (txd_uart),
    .rx_frame_error (rx_frame_error)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      byte_cnt_reg    <= 2'd0;
      timeout_cnt_reg <= '0;
      addr_reg        <= 32'd0;
      wdata_reg       <= '0;
      rdata_reg       <= '0;
      we_reg          <= 1'b0;
      req_reg         <= 1'b0;
      tx_data_reg     <= 8'd0;
      tx_valid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rx_accept) begin
            byte_cnt_reg <= 2'd0;
            if (is_opcode(rx_data)) begin
              we_reg    <= (rx_data == OP_WRITE);
              state_reg <= ADDR;
            end else begin
              tx_data_reg  <= RSP_ERR;
              tx_valid_reg <= 1'b1;
              state_reg    <= ERR;
            end
          end
        end
        ADDR: begin
          if (rx_frame_error) begin
            state_reg <= IDLE;
          end else if (rx_accept) begin
            addr_reg     <= {rx_data, addr_reg[31:8]};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              if (we_reg) begin
                state_reg <= WDATA;
              end else begin
                state_reg       <= BUS_REQ;
                req_reg         <= 1'b1;
                timeout_cnt_reg <= '0;
              end
            end
          end
        end
        WDATA: begin
          if (rx_frame_error) begin
            state_reg <= IDLE;
          end else if (rx_accept) begin
            wdata_reg    <= {rx_data, wdata_reg[DATA_WIDTH-1:8]};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              state_reg       <= BUS_REQ;
              req_reg         <= 1'b1;
              timeout_cnt_reg <= '0;
            end
          end
        end
        BUS_REQ: begin
          if (master_data_gnt_i) begin
            req_reg         <= 1'b0;
            timeout_cnt_reg <= '0;
            if (master_data_rvalid_i) begin
              rdata_reg    <= master_data_rdata_i;
              tx_data_reg  <= we_reg ? RSP_OK : master_data_rdata_i[7:0];
              tx_valid_reg <= 1'b1;
              byte_cnt_reg <= 2'd0;
              state_reg    <= RESP;
            end else begin
              state_reg <= BUS_WAIT;
            end
          end else if (timeout_cnt_reg == TO_LAST) begin
            req_reg      <= 1'b0;
            tx_data_reg  <= RSP_TIMEOUT;
            tx_valid_reg <= 1'b1;
            state_reg    <= ERR;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + TO_ONE;
          end
        end
        BUS_WAIT: begin
          if (master_data_rvalid_i) begin
            rdata_reg    <= master_data_rdata_i;
            tx_data_reg  <= we_reg ? RSP_OK : master_data_rdata_i[7:0];
            tx_valid_reg <= 1'b1;
            byte_cnt_reg <= 2'd0;
            state_reg    <= RESP;
          end else if (timeout_cnt_reg == TO_LAST) begin
            tx_data_reg  <= RSP_TIMEOUT;
            tx_valid_reg <= 1'b1;
            state_reg    <= ERR;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + TO_ONE;
          end
        end
        RESP: begin
          if (tx_ready) begin
            if (we_reg || byte_cnt_reg == 2'd3) begin
              tx_valid_reg <= 1'b0;
              state_reg    <= IDLE;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 2'd1;
              tx_data_reg  <= rdata_byte[byte_cnt_reg + 2'd1];
            end
          end
        end
        ERR: begin
          if (tx_ready) begin
            tx_valid_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_bus_master.md
UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 32, bus data width; fixed at 32.
- ADDR_WIDTH, 32, bus address width; allowed range 1..32.
- PRESCALE, 16'd54, UART prescale passed to axi_uart.
- BUS_TIMEOUT, 255, maximum number of cycles to wait for gnt, and separately for rvalid.

REQ-002 Ports SHALL be (clock and reset first):
- clk  input  1  sole clock.
- reset  input  1  asynchronous, active-low reset.
- rxd_uart  input  1  serial command input.
- txd_uart  output  1  serial response output.
- master_data_req_o  output  1  bus request.
- master_data_addr_o  output  ADDR_WIDTH  bus address.
- master_data_we_o  output  1  1 = write, 0 = read.
- master_data_be_o  output  4  byte enables; always 4'hF.
- master_data_wdata_o  output  32  write data.
- master_data_gnt_i  input  1  grant from slave.
- master_data_rvalid_i  input  1  response valid from slave.
- master_data_rdata_i  input  32  read data from slave.
- busy_o  output  1  high in every state except IDLE.

Function
REQ-003 The block SHALL be the initiator for the req/gnt/rvalid data bus: it converts UART command frames into single bus transactions and returns responses over UART.

REQ-004 Command frame: one opcode byte, then 4 address bytes LSB first. Opcode 0x57 ('W') is followed by 4 data bytes LSB first; opcode 0x52 ('R') has no data bytes.

REQ-005 Responses:
- Write complete: single byte 0x4B ('K').
- Read complete: 4 rdata bytes, LSB first.
- Unknown opcode: 0x45 ('E').
- Bus timeout: 0x54 ('T').

REQ-006 FSM states SHALL be IDLE, ADDR, WDATA, BUS_REQ, BUS_WAIT, RESP, ERR. A 2-bit byte counter indexes the address, data and response bytes.

REQ-007 Transitions:
- IDLE -> ADDR on opcode 'W' or 'R'; IDLE -> ERR on any other byte.
- ADDR -> WDATA (write) or BUS_REQ (read) after the 4th address byte.
- WDATA -> BUS_REQ after the 4th data byte.
- BUS_REQ -> BUS_WAIT when gnt is sampled high.
- BUS_WAIT -> RESP when rvalid is sampled high.
- RESP -> IDLE after the last response byte is accepted.
- ERR -> IDLE after the error byte is accepted.

REQ-008 master_data_req_o SHALL:
- assert in the cycle after entry to BUS_REQ;
- hold high, with addr/we/wdata stable, until gnt is sampled high;
- deassert in the cycle following gnt.

REQ-009 rdata SHALL be captured only in the cycle rvalid is high. rvalid arriving in the same cycle as gnt SHALL be accepted, moving directly to RESP.

REQ-010 Address bits above ADDR_WIDTH SHALL be discarded.

REQ-011 A timeout counter SHALL clear on entry to BUS_REQ and to BUS_WAIT. If it reaches BUS_TIMEOUT, req drops, the transaction aborts, and the FSM enters ERR sending 'T'.

REQ-012 An rx_frame_error pulse in any non-IDLE receive state (ADDR, WDATA) SHALL discard the partial frame and return to IDLE with no bus access and no response.

REQ-013 Response bytes SHALL be presented with s_axis_tvalid held until s_axis_tready. One byte is in flight at a time; byte order is strictly preserved.

REQ-014 Received bytes arriving during BUS_REQ, BUS_WAIT, RESP or ERR SHALL be dropped: m_axis_tready is low in those states.

Reset
REQ-015 On reset low, all outputs SHALL clear asynchronously:
- master_data_req_o, master_data_we_o, busy_o = 0.
- master_data_addr_o, master_data_wdata_o = 0.
- master_data_be_o = 4'hF.
- FSM = IDLE; counters = 0.

REQ-016 A reset asserted mid-transaction SHALL drop req within the same cycle, with no partial response sent afterwards.

REQ-017 The axi_uart rst input SHALL be driven by the inverted reset.

Structure
REQ-018 Opcode and response byte constants and the FSM state encoding SHALL live in a shared package, uart_bus_pkg.

REQ-019 There SHALL be exactly one sub-module: axi_uart, with prescale tied to PRESCALE.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write: frame 57 10 00 00 00 EF BE AD DE -> one bus write, addr 0x10, wdata 0xDEADBEEF, be F -> txd 4B.
- Read: frame 52 14 00 00 00, slave returns 0x12345678 after 3 cycles -> txd 78 56 34 12.
- Delayed grant: gnt withheld 5 cycles -> req high and addr stable for all 6 cycles; single transaction.
- Bad opcode and timeout:
  - opcode 0x41 -> txd 45, no req;
  - gnt never asserted with BUS_TIMEOUT=8 -> req drops after 8 cycles, txd 54.
- Frame error during the 3rd address byte -> no req, no txd; the next valid frame completes normally.
- Reset low during BUS_WAIT -> req 0 immediately, busy_o 0, no txd; a subsequent write succeeds.
